// File: rtl/mem_seq_pkg.sv
// Shared constants for the memory sequencer pair (write side and read side).
// Holds the FSM state encoding and the default memory geometry so both tops
// agree on widths without repeating literals.
package mem_seq_pkg;

  // Default memory geometry.
  localparam int unsigned MEM_ADRS_WIDTH = 2;
  localparam int unsigned MEM_WORD_DEPTH = 4;
  localparam int unsigned MEM_WORD_WIDTH = 8;

  // Read sequencer state encoding (kept as plain constants for legacy tools).
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/rd_adrs_counter.sv
// Read address counter for mem_read_sequencer.
// Counts 0 .. WORD_DEPTH-1 and flags the final word. The terminal value is
// WORD_DEPTH-1, so non-power-of-two depths never reach unused addresses.
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset
//   clear   : force the address back to 0 (wins over inc)
//   inc     : advance to the next address
//   adrs    : current address
//   is_last : adrs == WORD_DEPTH-1
module rd_adrs_counter #(
  parameter int unsigned ADRS_WIDTH = 2,
  parameter int unsigned WORD_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  inc,
  output logic [ADRS_WIDTH-1:0] adrs,
  output logic                  is_last
);

  localparam logic [ADRS_WIDTH-1:0] LastAdrs = ADRS_WIDTH'(WORD_DEPTH - 1);

  logic [ADRS_WIDTH-1:0] adrs_q, adrs_d;

  always_comb begin
    adrs_d = adrs_q;
    if (clear) begin
      adrs_d = '0;
    end else if (inc) begin
      // Wrap at the terminal word rather than the natural counter width.
      adrs_d = (adrs_q == LastAdrs) ? '0 : adrs_q + ADRS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adrs_q <= '0;
    end else begin
      adrs_q <= adrs_d;
    end
  end

  assign adrs    = adrs_q;
  assign is_last = (adrs_q == LastAdrs);

endmodule

// File: rtl/mem_read_sequencer.sv
// Reads WORD_DEPTH words of a synchronous-read memory in ascending order on a
// start pulse, presents each word on a valid/ready stream, then pulses done.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   start     : sequence request, only honoured while idle
//   rd_en     : memory read enable, one cycle per word
//   rd_adrs   : memory read address (the current word address)
//   rd_data   : memory read data, valid the cycle after rd_en
//   out_valid : out_data holds a word
//   out_ready : consumer accepts the word when out_valid is high
//   out_data  : registered word
//   out_last  : high with out_valid on the final word
//   busy      : any state other than idle
//   done      : one-cycle pulse after the final handshake
// All control outputs are decoded from registered state only.
module mem_read_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned ADRS_WIDTH = MEM_ADRS_WIDTH,
  parameter int unsigned WORD_DEPTH = MEM_WORD_DEPTH,
  parameter int unsigned WORD_WIDTH = MEM_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  rd_en,
  output logic [ADRS_WIDTH-1:0] rd_adrs,
  input  logic [WORD_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  logic [2:0]            state_q, state_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  cnt_clear;
  logic                  cnt_inc;
  logic [ADRS_WIDTH-1:0] adrs;
  logic                  is_last;

  rd_adrs_counter #(
    .ADRS_WIDTH (ADRS_WIDTH),
    .WORD_DEPTH (WORD_DEPTH)
  ) u_rd_adrs_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .adrs    (adrs),
    .is_last (is_last)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_READ;
          cnt_clear = 1'b1;
        end
      end
      S_READ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Memory returns the word one cycle after rd_en.
        data_d  = rd_data;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          if (is_last) begin
            state_d = S_DONE;
          end else begin
            cnt_inc = 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        cnt_clear = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        cnt_clear = 1'b1;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign rd_en     = (state_q == S_READ);
  assign rd_adrs   = adrs;
  assign out_valid = (state_q == S_HOLD);
  assign out_last  = (state_q == S_HOLD) && is_last;
  assign out_data  = data_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_read_sequencer.sv
// Bench for mem_read_sequencer: a depth-4 instance and a depth-3 instance,
// each with its own synchronous-read memory. A transaction-level model
// predicts every output each cycle; directed tests add literal expectations.
module tb_mem_read_sequencer;

  localparam int unsigned AW = 2;
  localparam int unsigned WW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start     [2];
  logic          out_ready [2];
  logic          rd_en     [2];
  logic          out_valid [2];
  logic          out_last  [2];
  logic          busy      [2];
  logic          done      [2];
  logic [AW-1:0] rd_adrs   [2];
  logic [WW-1:0] rd_data   [2];
  logic [WW-1:0] out_data  [2];
  logic [WW-1:0] mem       [2][4];

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_read_sequencer #(.ADRS_WIDTH(2), .WORD_DEPTH(4), .WORD_WIDTH(8)) dut4 (
    .clk(clk), .rst(rst), .start(start[0]), .rd_en(rd_en[0]), .rd_adrs(rd_adrs[0]),
    .rd_data(rd_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_last(out_last[0]), .busy(busy[0]), .done(done[0])
  );

  mem_read_sequencer #(.ADRS_WIDTH(2), .WORD_DEPTH(3), .WORD_WIDTH(8)) dut3 (
    .clk(clk), .rst(rst), .start(start[1]), .rd_en(rd_en[1]), .rd_adrs(rd_adrs[1]),
    .rd_data(rd_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_last(out_last[1]), .busy(busy[1]), .done(done[1])
  );

  // Synchronous-read memories.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_en[i]) rd_data[i] <= mem[i][rd_adrs[i]];
    end
  end

  function automatic int depth_of(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: per instance, a sequence is a list of words; each word is issued
  // (1 cycle), awaited (1 cycle) then presented until accepted. After the
  // final acceptance comes a single done cycle.
  bit            m_active [2];
  bit            m_done   [2];
  int            m_k      [2];  // word index within the sequence
  int            m_t      [2];  // cycles spent on the current word, saturates at 2
  logic [WW-1:0] m_last   [2];  // most recently fetched word

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_active[i] <= 1'b0;
        m_done[i]   <= 1'b0;
        m_k[i]      <= 0;
        m_t[i]      <= 0;
        m_last[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_done[i]) begin
          m_done[i] <= 1'b0;
        end else if (!m_active[i]) begin
          if (start[i]) begin
            m_active[i] <= 1'b1;
            m_k[i]      <= 0;
            m_t[i]      <= 0;
          end
        end else if (m_t[i] < 2) begin
          if (m_t[i] == 1) m_last[i] <= mem[i][m_k[i]];
          m_t[i] <= m_t[i] + 1;
        end else if (out_ready[i]) begin
          if (m_k[i] == depth_of(i) - 1) begin
            m_active[i] <= 1'b0;
            m_done[i]   <= 1'b1;
          end else begin
            m_k[i] <= m_k[i] + 1;
            m_t[i] <= 0;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int exp_adrs;
        bit exp_valid;
        exp_valid = m_active[i] && (m_t[i] >= 2);
        exp_adrs  = m_active[i] ? m_k[i] : (m_done[i] ? depth_of(i) - 1 : 0);
        chk($sformatf("m%0d_rd_en", i), 32'(rd_en[i]), 32'(m_active[i] && m_t[i] == 0));
        chk($sformatf("m%0d_rd_adrs", i), 32'(rd_adrs[i]), 32'(exp_adrs));
        chk($sformatf("m%0d_out_valid", i), 32'(out_valid[i]), 32'(exp_valid));
        chk($sformatf("m%0d_out_last", i), 32'(out_last[i]),
            32'(exp_valid && m_k[i] == depth_of(i) - 1));
        chk($sformatf("m%0d_out_data", i), 32'(out_data[i]), 32'(m_last[i]));
        chk($sformatf("m%0d_busy", i), 32'(busy[i]), 32'(m_active[i] || m_done[i]));
        chk($sformatf("m%0d_done", i), 32'(done[i]), 32'(m_done[i]));
      end
    end
  end

  // Leaves the bench just after the edge that samples start (start of cycle 1).
  task automatic pulse_start(input int i);
    @(posedge clk) #1 start[i] = 1'b1;
    @(posedge clk) #1 start[i] = 1'b0;
  endtask

  initial begin
    int hs;
    int nd;
    for (int i = 0; i < 2; i++) begin
      start[i]     = 1'b0;
      out_ready[i] = 1'b1;
      rd_data[i]   = '0;
    end
    mem[0][0] = 8'h11; mem[0][1] = 8'h22; mem[0][2] = 8'h33; mem[0][3] = 8'h44;
    mem[1][0] = 8'hA1; mem[1][1] = 8'hB2; mem[1][2] = 8'hC3; mem[1][3] = 8'hD4;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en", 32'(rd_en[0]), 32'd0);
    chk("rst_rd_adrs", 32'(rd_adrs[0]), 32'd0);
    chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_out_data", 32'(out_data[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    @(negedge clk) #2 rst = 1'b1;
    chk_en = 1'b1;

    // Back-to-back read, ready held high.
    pulse_start(0);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_rd_en_c%0d", c), 32'(rd_en[0]),
          32'(c == 1 || c == 4 || c == 7 || c == 10));
      if (c == 1 || c == 4 || c == 7 || c == 10)
        chk($sformatf("b2b_rd_adrs_c%0d", c), 32'(rd_adrs[0]), 32'((c - 1) / 3));
      chk($sformatf("b2b_valid_c%0d", c), 32'(out_valid[0]),
          32'(c == 3 || c == 6 || c == 9 || c == 12));
      if (c == 3 || c == 6 || c == 9 || c == 12)
        chk($sformatf("b2b_data_c%0d", c), 32'(out_data[0]), 32'(8'h11 * (c / 3)));
      chk($sformatf("b2b_last_c%0d", c), 32'(out_last[0]), 32'(c == 12));
      chk($sformatf("b2b_done_c%0d", c), 32'(done[0]), 32'(c == 13));
      chk($sformatf("b2b_busy_c%0d", c), 32'(busy[0]), 32'(c <= 13));
    end

    // Backpressure: ready low for cycles 6..10 while 0x22 is presented.
    pulse_start(0);
    for (int c = 1; c <= 19; c++) begin
      out_ready[0] = !(c >= 6 && c <= 10);
      @(negedge clk);
      if (c >= 6 && c <= 11) begin
        chk($sformatf("bp_valid_c%0d", c), 32'(out_valid[0]), 32'd1);
        chk($sformatf("bp_data_c%0d", c), 32'(out_data[0]), 32'h22);
        chk($sformatf("bp_adrs_c%0d", c), 32'(rd_adrs[0]), 32'd1);
        chk($sformatf("bp_rd_en_c%0d", c), 32'(rd_en[0]), 32'd0);
      end
      chk($sformatf("bp_done_c%0d", c), 32'(done[0]), 32'(c == 18));
      chk($sformatf("bp_busy_c%0d", c), 32'(busy[0]), 32'(c <= 18));
      @(posedge clk) #1;
    end
    out_ready[0] = 1'b1;

    // Start while busy, including a start in the done cycle.
    pulse_start(0);
    hs = 0;
    nd = 0;
    for (int c = 1; c <= 16; c++) begin
      start[0] = (c == 2 || c == 8 || c == 13);
      @(negedge clk);
      if (out_valid[0] && out_ready[0]) hs++;
      if (done[0]) nd++;
      if (c >= 14) chk($sformatf("sb_idle_c%0d", c), 32'(busy[0]), 32'd0);
      @(posedge clk) #1;
    end
    start[0] = 1'b0;
    chk("sb_handshakes", 32'(hs), 32'd4);
    chk("sb_done_pulses", 32'(nd), 32'd1);

    // Asynchronous reset during presentation of the third word.
    pulse_start(0);
    for (int c = 1; c <= 9; c++) @(negedge clk);
    chk("ar_pre_data", 32'(out_data[0]), 32'h33);
    chk("ar_pre_valid", 32'(out_valid[0]), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("ar_rd_en", 32'(rd_en[0]), 32'd0);
    chk("ar_rd_adrs", 32'(rd_adrs[0]), 32'd0);
    chk("ar_out_valid", 32'(out_valid[0]), 32'd0);
    chk("ar_out_last", 32'(out_last[0]), 32'd0);
    chk("ar_out_data", 32'(out_data[0]), 32'd0);
    chk("ar_busy", 32'(busy[0]), 32'd0);
    chk("ar_done", 32'(done[0]), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ar_no_done", 32'(done[0]), 32'd0);
    end
    pulse_start(0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("ar_restart_rd_en", 32'(rd_en[0]), 32'd1);
        chk("ar_restart_adrs", 32'(rd_adrs[0]), 32'd0);
      end
      if (c == 3) begin
        chk("ar_restart_valid", 32'(out_valid[0]), 32'd1);
        chk("ar_restart_data", 32'(out_data[0]), 32'h11);
      end
    end
    repeat (12) @(posedge clk);
    #1;

    // Non-power-of-two depth on the second instance.
    pulse_start(1);
    hs = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (out_valid[1] && out_ready[1]) hs++;
      chk($sformatf("d3_rd_en_c%0d", c), 32'(rd_en[1]), 32'(c == 1 || c == 4 || c == 7));
      if (rd_en[1]) chk($sformatf("d3_adrs_c%0d", c), 32'(rd_adrs[1]), 32'((c - 1) / 3));
      chk($sformatf("d3_adrs_range_c%0d", c), 32'(rd_adrs[1] < 2'd3), 32'd1);
      chk($sformatf("d3_last_c%0d", c), 32'(out_last[1]), 32'(c == 9));
      chk($sformatf("d3_done_c%0d", c), 32'(done[1]), 32'(c == 10));
      if (c == 9) chk("d3_last_data", 32'(out_data[1]), 32'hC3);
    end
    chk("d3_handshakes", 32'(hs), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
